// File: rtl/branch_ctrl.sv
// Program-run sequencer and branch resolver driving the PC's start/jumpFlag/target inputs.
// Optional per-run taken-branch counter (taken_cnt) is built when BRANCH_STATS_EN is defined.
module branch_ctrl #(
  parameter int TGT_BITS = 8,
  parameter int TIMEOUT  = 4095
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                instr_valid,
  input  logic                is_branch,
  input  logic                is_jump,
  input  logic                is_halt,
  input  logic                cond_zero,
  input  logic                br_on_zero,
  input  logic [TGT_BITS-1:0] label,
  output logic                start,
  output logic                jumpFlag,
  output logic [TGT_BITS-1:0] target,
  output logic                instr_kill,
  output logic                busy,
  output logic                done,
`ifdef BRANCH_STATS_EN
  output logic [15:0]         taken_cnt,
`endif
  output logic                timed_out
);

  localparam int WD_BITS = $clog2(TIMEOUT + 1);
  localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT);
  localparam logic [WD_BITS-1:0] WD_MAX   = {WD_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state_reg;
  logic                start_reg;
  logic                jump_reg;
  logic [TGT_BITS-1:0] target_reg;
  logic                kill_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                timed_out_reg;
  logic [WD_BITS-1:0]  wd_reg;
  logic [WD_BITS-1:0]  wd_next;
  logic                wd_expire;
  logic                taken;
`ifdef BRANCH_STATS_EN
  logic [15:0]         cnt_reg;
`endif

  // Watchdog value including the current RUN/FLUSH cycle; saturates instead of wrapping.
  assign wd_next   = (wd_reg == WD_MAX) ? wd_reg : wd_reg + 1'b1;
  assign wd_expire = (wd_next >= WD_LIMIT);
  assign taken     = is_jump | (is_branch & (cond_zero == br_on_zero));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      start_reg     <= 1'b0;
      jump_reg      <= 1'b0;
      target_reg    <= '0;
      kill_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      timed_out_reg <= 1'b0;
      wd_reg        <= '0;
`ifdef BRANCH_STATS_EN
      cnt_reg       <= '0;
`endif
    end else begin
      start_reg <= 1'b0;
      jump_reg  <= 1'b0;
      kill_reg  <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            state_reg     <= S_START;
            start_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            timed_out_reg <= 1'b0;
            wd_reg        <= '0;
`ifdef BRANCH_STATS_EN
            cnt_reg       <= '0;
`endif
          end
        end
        S_START: begin
          state_reg <= S_RUN;
          wd_reg    <= '0;
        end
        S_RUN: begin
          wd_reg <= wd_next;
          // Watchdog expiry outranks halt and any jump decided this cycle.
          if (wd_expire) begin
            state_reg     <= S_DONE;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            timed_out_reg <= 1'b1;
          end else if (instr_valid && is_halt) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else if (instr_valid && taken) begin
            state_reg  <= S_FLUSH;
            jump_reg   <= 1'b1;
            target_reg <= label;
`ifdef BRANCH_STATS_EN
            if (cnt_reg != 16'hFFFF) begin
              cnt_reg <= cnt_reg + 16'd1;
            end
`endif
          end
        end
        S_FLUSH: begin
          // The instruction presented now was fetched down the wrong path.
          wd_reg <= wd_next;
          if (wd_expire) begin
            state_reg     <= S_DONE;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            timed_out_reg <= 1'b1;
          end else begin
            state_reg <= S_RUN;
            kill_reg  <= 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign start      = start_reg;
  assign jumpFlag   = jump_reg;
  assign target     = target_reg;
  assign instr_kill = kill_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign timed_out  = timed_out_reg;
`ifdef BRANCH_STATS_EN
  assign taken_cnt  = cnt_reg;
`endif

endmodule
